// File: rtl/tt_pkg.sv
// Shared types and constants for the 7-input truth-table extractor.
package tt_pkg;

  localparam int unsigned NVARS     = 7;
  localparam int unsigned NMINTERMS = 128;
  localparam int unsigned ONES_W    = 8;
  localparam int unsigned CNT_W     = 4;

  localparam logic [7:0] NO_MISS = 8'hFF;

  typedef logic [NMINTERMS-1:0] tt_t;
  typedef logic [NVARS-1:0]     minterm_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/tt_settle_ctr.sv
// Slot counter: strobes once every SETTLE+1 enabled cycles so the FUT output
// is sampled only after its latency has elapsed.
module tt_settle_ctr
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic strobe_c
);

  logic [CNT_W-1:0] cnt;

  assign strobe_c = en && (cnt == CNT_W'(SETTLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= strobe_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tt_extractor.sv
// Sweeps all 128 minterms into an attached 7-input function and builds its
// truth table and onset count. Define TT_EXTRACTOR_CMP_EN to add exp_tt compare.
module tt_extractor
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE = 0,
  parameter int unsigned NVARS  = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic [6:0]          x,
  input  logic                f_in,
  output logic [127:0]        tt,
  output logic [7:0]          ones,
  output logic                res_valid,
  input  logic                res_ready
`ifdef TT_EXTRACTOR_CMP_EN
  ,
  input  logic [127:0]        exp_tt,
  output logic                match,
  output logic [7:0]          first_miss
`endif
);

  if (NVARS != tt_pkg::NVARS) begin : g_bad_nvars
    $error("tt_extractor: NVARS must be 7");
  end
  if (SETTLE > 15) begin : g_bad_settle
    $error("tt_extractor: SETTLE must be in 0..15");
  end

  state_t   state;
  minterm_t idx;
  logic     strobe_c;
  logic     start_acc_c;

  assign start_acc_c = (state == IDLE) && start;
  assign x           = idx;

  tt_settle_ctr #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_acc_c),
    .en       (state == RUN),
    .strobe_c (strobe_c)
  );

`ifdef TT_EXTRACTOR_CMP_EN
  logic miss_c;
  assign miss_c = (f_in != exp_tt[idx]);
`endif

  // Sweep FSM and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      tt         <= '0;
      ones       <= '0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
`ifdef TT_EXTRACTOR_CMP_EN
      match      <= 1'b0;
      first_miss <= NO_MISS;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            idx        <= '0;
            tt         <= '0;
            ones       <= '0;
            busy       <= 1'b1;
`ifdef TT_EXTRACTOR_CMP_EN
            match      <= 1'b0;
            first_miss <= NO_MISS;
`endif
          end
        end
        RUN: begin
          if (strobe_c) begin
            tt[idx] <= f_in;
            ones    <= ones + ONES_W'(f_in);
            idx     <= idx + minterm_t'(1);
`ifdef TT_EXTRACTOR_CMP_EN
            // Minterms arrive in ascending order, so the first miss is the lowest.
            if (miss_c && (first_miss == NO_MISS)) begin
              first_miss <= {1'b0, idx};
            end
`endif
            if (idx == minterm_t'(NMINTERMS - 1)) begin
              state     <= DONE;
              busy      <= 1'b0;
              res_valid <= 1'b1;
`ifdef TT_EXTRACTOR_CMP_EN
              match     <= (first_miss == NO_MISS) && !miss_c;
`endif
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_extractor.sv
// Directed bench for tt_extractor with a scoreboard of expected tables.
module tb_tt_extractor;
  import tt_pkg::*;

  typedef struct {
    logic [127:0] tt;
    logic [7:0]   ones;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_r = 1'b0;
  logic res_ready = 1'b0;
  int   cur = 0;
  int   mode = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  logic         start0, start1;
  logic         busy0, busy1, rv0, rv1, f0, f1;
  logic [6:0]   x0, x1;
  logic [127:0] tt0, tt1;
  logic [7:0]   ones0, ones1;
  logic         p1, p2;
  logic [127:0] exp_tt0 = '0;
  logic         match0, match1;
  logic [7:0]   fm0, fm1;

  assign start0 = start_r && (cur == 0);
  assign start1 = start_r && (cur == 1);

  function automatic logic fmodel(input int c, input int m, input int i);
    logic [6:0] v;
    v = 7'(i);
    if (c == 1) return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    case (m)
      1:       return v[0];
      2:       return &v;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [127:0] model_tt(input int c, input int m);
    logic [127:0] t;
    for (int i = 0; i < 128; i++) t[i] = fmodel(c, m, i);
    return t;
  endfunction

  // Function under test for the SETTLE=0 instance: combinational.
  always_comb f0 = fmodel(0, mode, int'(x0));

  // Function under test for the SETTLE=2 instance: MAJ(x0,x1,x2), 2-stage pipe.
  always @(posedge clk) begin
    p1 <= fmodel(1, 0, int'(x1));
    p2 <= p1;
  end
  assign f1 = p2;

  tt_extractor #(.SETTLE(0), .NVARS(7)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .x(x0), .f_in(f0),
    .tt(tt0), .ones(ones0), .res_valid(rv0), .res_ready(res_ready)
`ifdef TT_EXTRACTOR_CMP_EN
    , .exp_tt(exp_tt0), .match(match0), .first_miss(fm0)
`endif
  );

  tt_extractor #(.SETTLE(2), .NVARS(7)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .x(x1), .f_in(f1),
    .tt(tt1), .ones(ones1), .res_valid(rv1), .res_ready(res_ready)
`ifdef TT_EXTRACTOR_CMP_EN
    , .exp_tt(128'h0), .match(match1), .first_miss(fm1)
`endif
  );

  logic         busy_s, rv_s;
  logic [6:0]   x_s;
  logic [127:0] tt_s;
  logic [7:0]   ones_s;
  always_comb begin
    busy_s = (cur == 0) ? busy0 : busy1;
    rv_s   = (cur == 0) ? rv0   : rv1;
    x_s    = (cur == 0) ? x0    : x1;
    tt_s   = (cur == 0) ? tt0   : tt1;
    ones_s = (cur == 0) ? ones0 : ones1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch();
    exp_t e;
    e.tt   = model_tt(cur, mode);
    e.ones = 8'($countones(e.tt));
    sbq.push_back(e);
    @(negedge clk) start_r = 1'b1;
    @(negedge clk) start_r = 1'b0;
    chk("busy_on", 128'(busy_s), 128'(1));
    chk("x_first", 128'(x_s), 128'(0));
  endtask

  task automatic finish_sweep(input int lat, input bit mid_start);
    int   k;
    exp_t e;
    k = 0;
    while (!rv_s && k < lat + 50) begin
      @(negedge clk);
      k++;
      start_r = mid_start && (k == 10);
      if (k == 5) chk("x_run", 128'(x_s), 128'(5 / (lat / 128)));
    end
    start_r = 1'b0;
    chk("latency", 128'(k), 128'(lat));
    chk("busy_done", 128'(busy_s), 128'(0));
    chk("sb_nonempty", 128'(sbq.size() != 0), 128'(1));
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("tt", tt_s, e.tt);
      chk("ones", 128'(ones_s), 128'(e.ones));
    end
  endtask

  task automatic accept();
    @(negedge clk) res_ready = 1'b1;
    @(negedge clk) res_ready = 1'b0;
    chk("rv_drop", 128'(rv_s), 128'(0));
  endtask

  initial begin
    int k;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy0), 128'(0));
    chk("rst_x", 128'(x0), 128'(0));
    chk("rst_tt", tt0, 128'(0));
    chk("rst_ones", 128'(ones0), 128'(0));
    chk("rst_rv", 128'(rv0), 128'(0));
`ifdef TT_EXTRACTOR_CMP_EN
    chk("rst_match", 128'(match0), 128'(0));
    chk("rst_first_miss", 128'(fm0), 128'hFF);
`endif
    rst_n = 1'b1;

    // Constant zero.
    cur = 0; mode = 0;
    launch();
    finish_sweep(128, 1'b0);
    accept();

    // f = x0, with a start pulse mid-sweep that must be ignored.
    mode = 1;
    launch();
    finish_sweep(128, 1'b1);
    chk("tt_x0_lit", tt0, {32{4'hA}});
    chk("ones_x0_lit", 128'(ones0), 128'd64);
    accept();

    // MAJ(x0,x1,x2) through a 2-stage pipeline, SETTLE=2.
    cur = 1;
    launch();
    finish_sweep(384, 1'b0);
    chk("tt_maj_lit", tt1, {16{8'hE8}});
    accept();

    // AND of all inputs; hold off acceptance and poke start in DONE.
    cur = 0; mode = 2;
    launch();
    finish_sweep(128, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start_r = ~start_r;
      chk("rv_hold", 128'(rv0), 128'(1));
    end
    start_r = 1'b0;
    chk("tt_and_hold", tt0, {1'b1, 127'b0});
    chk("ones_and_hold", 128'(ones0), 128'd1);
    chk("busy_hold", 128'(busy0), 128'(0));
    accept();
    chk("tt_keep_idle", tt0, {1'b1, 127'b0});

    // Asynchronous reset at idx=60, then a clean sweep.
    mode = 1;
    launch();
    k = 0;
    while (x0 != 7'd60 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_60", 128'(x0), 128'd60);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy0), 128'(0));
    chk("mid_rst_tt", tt0, 128'(0));
    chk("mid_rst_x", 128'(x0), 128'(0));
    chk("mid_rst_ones", 128'(ones0), 128'(0));
    sbq.delete();
    @(negedge clk) rst_n = 1'b1;
    launch();
    finish_sweep(128, 1'b0);
    accept();

`ifdef TT_EXTRACTOR_CMP_EN
    mode = 1;
    exp_tt0 = model_tt(0, 1) ^ (128'(1) << 5);
    launch();
    finish_sweep(128, 1'b0);
    chk("match_bad", 128'(match0), 128'(0));
    chk("first_miss_5", 128'(fm0), 128'd5);
    accept();
    exp_tt0 = model_tt(0, 1);
    launch();
    finish_sweep(128, 1'b0);
    chk("match_ok", 128'(match0), 128'(1));
    chk("first_miss_none", 128'(fm0), 128'hFF);
    accept();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
